// File: rtl/axis_fifo_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI-Stream FIFO from NUM_PORT requesters.
// A grant is held from the first beat until TLAST is accepted; new packets need MIN_FREE FIFO slots.
module axis_fifo_rr_arbiter #(
   parameter int NUM_PORT   = 4,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 512,
   parameter int MIN_FREE   = 16,
   parameter int ID_W       = 2
) (
   input  logic                         iSYS_CLK,
   input  logic                         iSYS_RST,
   input  logic [NUM_PORT-1:0]          iS_AXIS_TVALID,
   output logic [NUM_PORT-1:0]          oS_AXIS_TREADY,
   input  logic [NUM_PORT*DATA_W-1:0]   iS_AXIS_TDATA,
   input  logic [NUM_PORT*DATA_W/8-1:0] iS_AXIS_TKEEP,
   input  logic [NUM_PORT-1:0]          iS_AXIS_TLAST,
   output logic                         oM_AXIS_TVALID,
   input  logic                         iM_AXIS_TREADY,
   output logic [DATA_W-1:0]            oM_AXIS_TDATA,
   output logic [DATA_W/8-1:0]          oM_AXIS_TKEEP,
   output logic                         oM_AXIS_TLAST,
   output logic [ID_W-1:0]              oM_AXIS_TID,
   input  logic [31:0]                  iFIFO_DATA_COUNT,
   output logic [NUM_PORT-1:0]          oGRANT,
   output logic                         oBUSY,
   output logic [31:0]                  oPKT_CNT
);

   localparam int KEEP_W = DATA_W / 8;

   typedef enum logic {ST_IDLE, ST_XFER} stateT;

   stateT             state;
   logic [ID_W-1:0]   lastGrant;
   logic [31:0]       freeCnt;
   logic              startOk;
   logic              reqFound;
   logic [ID_W-1:0]   reqIdx;
   int                bestDist;

   // An overfull count means no room at all rather than a wrapped huge value.
   assign freeCnt = (iFIFO_DATA_COUNT > 32'(FIFO_DEPTH)) ? 32'd0
                                                         : 32'(FIFO_DEPTH) - iFIFO_DATA_COUNT;
   assign startOk = (freeCnt >= 32'(MIN_FREE));

   // Closest valid port after lastGrant wins; distance 0 is lastGrant+1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      reqFound = 1'b0;
      reqIdx   = '0;
      bestDist = NUM_PORT;
      for (int k = 0; k < NUM_PORT; k++) begin
         if (iS_AXIS_TVALID[k] &&
             (((k + NUM_PORT - 1 - int'(lastGrant)) % NUM_PORT) < bestDist)) begin
            bestDist = (k + NUM_PORT - 1 - int'(lastGrant)) % NUM_PORT;
            reqFound = 1'b1;
            reqIdx   = ID_W'(k);
         end
      end
   end

   always_comb begin
      oM_AXIS_TVALID = 1'b0;
      oM_AXIS_TDATA  = '0;
      oM_AXIS_TKEEP  = '0;
      oM_AXIS_TLAST  = 1'b0;
      oS_AXIS_TREADY = '0;
      if (state == ST_XFER) begin
         for (int k = 0; k < NUM_PORT; k++) begin
            if (oM_AXIS_TID == ID_W'(k)) begin
               oM_AXIS_TVALID    = iS_AXIS_TVALID[k];
               oM_AXIS_TDATA     = iS_AXIS_TDATA[k*DATA_W +: DATA_W];
               oM_AXIS_TKEEP     = iS_AXIS_TKEEP[k*KEEP_W +: KEEP_W];
               oM_AXIS_TLAST     = iS_AXIS_TLAST[k];
               oS_AXIS_TREADY[k] = iM_AXIS_TREADY;
            end
         end
      end
   end

   always_ff @(posedge iSYS_CLK) begin
      if (iSYS_RST) begin
         state       <= ST_IDLE;
         oGRANT      <= '0;
         oM_AXIS_TID <= '0;
         oBUSY       <= 1'b0;
         oPKT_CNT    <= '0;
         lastGrant   <= ID_W'(NUM_PORT - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (reqFound && startOk) begin
                  oGRANT      <= NUM_PORT'(1) << reqIdx;
                  oM_AXIS_TID <= reqIdx;
                  oBUSY       <= 1'b1;
                  state       <= ST_XFER;
               end
            end
            ST_XFER: begin
               // Grant stays locked through source bubbles and sink backpressure.
               if (oM_AXIS_TVALID && iM_AXIS_TREADY && oM_AXIS_TLAST) begin
                  oPKT_CNT  <= oPKT_CNT + 32'd1;
                  lastGrant <= oM_AXIS_TID;
                  oGRANT    <= '0;
                  oBUSY     <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Directed bench for axis_fifo_rr_arbiter: single packet, round-robin, lock, threshold,
// backpressure and mid-packet reset, plus per-cycle one-hot invariants.
module tb_axis_fifo_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int KW = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     sValid = '0;
   logic [NP-1:0]     sReady;
   logic [NP*DW-1:0]  sData = '0;
   logic [NP*KW-1:0]  sKeep = '0;
   logic [NP-1:0]     sLast = '0;
   logic              mValid;
   logic              mReady = 1'b0;
   logic [DW-1:0]     mData;
   logic [KW-1:0]     mKeep;
   logic              mLast;
   logic [1:0]        tid;
   logic [31:0]       count = '0;
   logic [NP-1:0]     grant;
   logic              busy;
   logic [31:0]       pktCnt;

   int errors = 0;
   int checks = 0;
   int xferCnt = 0;
   int x0;
   bit monOn = 1'b0;

   always #5 clk = ~clk;

   axis_fifo_rr_arbiter dut (
      .iSYS_CLK         (clk),
      .iSYS_RST         (rst),
      .iS_AXIS_TVALID   (sValid),
      .oS_AXIS_TREADY   (sReady),
      .iS_AXIS_TDATA    (sData),
      .iS_AXIS_TKEEP    (sKeep),
      .iS_AXIS_TLAST    (sLast),
      .oM_AXIS_TVALID   (mValid),
      .iM_AXIS_TREADY   (mReady),
      .oM_AXIS_TDATA    (mData),
      .oM_AXIS_TKEEP    (mKeep),
      .oM_AXIS_TLAST    (mLast),
      .oM_AXIS_TID      (tid),
      .iFIFO_DATA_COUNT (count),
      .oGRANT           (grant),
      .oBUSY            (busy),
      .oPKT_CNT         (pktCnt)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic setPort(input int p, input bit v, input logic [63:0] d, input bit l);
      sValid[p]          = v;
      sData[p*DW +: DW]  = d;
      sKeep[p*KW +: KW]  = v ? 8'hFF : 8'h00;
      sLast[p]           = l;
   endtask

   always @(posedge clk)
      if (!rst && mValid && mReady) xferCnt++;

   always @(negedge clk) begin
      if (monOn) begin
         checkVal("grant_onehot0", 64'($onehot0(grant)), 64'd1);
         checkVal("tready_onehot0", 64'($onehot0(sReady)), 64'd1);
         if (grant != '0) checkVal("tid_matches_grant", 64'(grant), 64'(1) << tid);
      end
   end

   initial begin
      // Reset state
      step; step;
      checkVal("rst_grant", grant, 0);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_pktcnt", pktCnt, 0);
      checkVal("rst_tid", tid, 0);
      checkVal("rst_tready", sReady, 0);
      checkVal("rst_mvalid", mValid, 0);
      rst = 1'b0;
      monOn = 1'b1;

      // Single requester, two beats
      mReady = 1'b1;
      setPort(0, 1, 64'hDEADBEEFCAFEBABE, 0);
      #1;
      checkVal("idle_mvalid", mValid, 0);
      checkVal("idle_mdata", mData, 0);
      step;
      checkVal("t1_grant", grant, 4'b0001);
      checkVal("t1_busy", busy, 1);
      checkVal("t1_tid", tid, 0);
      checkVal("t1_mvalid", mValid, 1);
      checkVal("t1_beat0", mData, 64'hDEADBEEFCAFEBABE);
      checkVal("t1_keep", mKeep, 8'hFF);
      checkVal("t1_tready", sReady, 4'b0001);
      step;
      setPort(0, 1, 64'h0123456789ABCDEF, 1);
      #1;
      checkVal("t1_beat1", mData, 64'h0123456789ABCDEF);
      checkVal("t1_last", mLast, 1);
      checkVal("t1_pktcnt_mid", pktCnt, 0);
      step;
      setPort(0, 0, 0, 0);
      checkVal("t1_idle_grant", grant, 0);
      checkVal("t1_idle_busy", busy, 0);
      checkVal("t1_pktcnt", pktCnt, 1);
      checkVal("t1_idle_tready", sReady, 0);

      // Round-robin from a fresh reset: order 0,1,2,3,0
      rst = 1'b1;
      step;
      rst = 1'b0;
      for (int p = 0; p < NP; p++) setPort(p, 1, 64'h1000 + 64'(p), 1);
      for (int n = 0; n < 5; n++) begin
         step;
         checkVal($sformatf("rr%0d_grant", n), grant, 64'(1) << (n % NP));
         checkVal($sformatf("rr%0d_tid", n), tid, 64'(n % NP));
         checkVal($sformatf("rr%0d_data", n), mData, 64'h1000 + 64'(n % NP));
         step;
         checkVal($sformatf("rr%0d_pktcnt", n), pktCnt, 64'(n + 1));
         checkVal($sformatf("rr%0d_idle", n), grant, 0);
      end
      for (int p = 0; p < NP; p++) setPort(p, 0, 0, 0);

      // Packet lock: port 1 with a 3-cycle bubble while port 2 waits
      x0 = xferCnt;
      setPort(1, 1, 64'hA0, 0);
      setPort(2, 1, 64'hB0, 1);
      step;
      checkVal("lock_grant", grant, 4'b0010);
      step;
      setPort(1, 1, 64'hA1, 0);
      step;
      setPort(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step;
         checkVal($sformatf("lock_bub%0d_grant", i), grant, 4'b0010);
         checkVal($sformatf("lock_bub%0d_tready", i), sReady, 4'b0010);
         checkVal($sformatf("lock_bub%0d_mvalid", i), mValid, 0);
      end
      setPort(1, 1, 64'hA2, 0);
      step;
      setPort(1, 1, 64'hA3, 1);
      #1;
      checkVal("lock_last", mLast, 1);
      step;
      setPort(1, 0, 0, 0);
      checkVal("lock_release", grant, 0);
      checkVal("lock_pktcnt", pktCnt, 6);
      checkVal("lock_beats", 64'(xferCnt - x0), 4);
      step;
      checkVal("lock_next_grant", grant, 4'b0100);
      checkVal("lock_next_data", mData, 64'hB0);
      step;
      setPort(2, 0, 0, 0);
      checkVal("lock_next_pktcnt", pktCnt, 7);

      // Free-space threshold
      setPort(0, 1, 64'hC0, 1);
      count = 32'd497;
      step;
      checkVal("thr497_a", grant, 0);
      step;
      checkVal("thr497_b", grant, 0);
      count = 32'd496;
      step;
      checkVal("thr496_grant", grant, 4'b0001);
      step;
      count = 32'd600;
      checkVal("thr496_pktcnt", pktCnt, 8);
      step;
      checkVal("thr600_a", grant, 0);
      step;
      checkVal("thr600_b", grant, 0);
      checkVal("thr600_busy", busy, 0);
      setPort(0, 0, 0, 0);
      count = 32'd0;

      // Backpressure: ready 1,0,0,1 then 1 over a 3-beat packet on port 3
      x0 = xferCnt;
      setPort(3, 1, 64'hD0, 0);
      step;
      checkVal("bp_grant", grant, 4'b1000);
      checkVal("bp_tready0", sReady, 4'b1000);
      checkVal("bp_data0", mData, 64'hD0);
      step;
      setPort(3, 1, 64'hD1, 0);
      mReady = 1'b0;
      #1;
      checkVal("bp_tready_low", sReady, 0);
      checkVal("bp_data1", mData, 64'hD1);
      step;
      checkVal("bp_hold_grant", grant, 4'b1000);
      checkVal("bp_hold_data", mData, 64'hD1);
      step;
      mReady = 1'b1;
      #1;
      checkVal("bp_tready_high", sReady, 4'b1000);
      checkVal("bp_data1_again", mData, 64'hD1);
      step;
      setPort(3, 1, 64'hD2, 1);
      step;
      setPort(3, 0, 0, 0);
      checkVal("bp_release", grant, 0);
      checkVal("bp_pktcnt", pktCnt, 9);
      checkVal("bp_beats", 64'(xferCnt - x0), 3);

      // Reset after beat 2 of 4
      setPort(2, 1, 64'hE0, 0);
      step;
      checkVal("mrst_grant", grant, 4'b0100);
      step;
      setPort(2, 1, 64'hE1, 0);
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      checkVal("mrst_grant_clr", grant, 0);
      checkVal("mrst_busy", busy, 0);
      checkVal("mrst_pktcnt", pktCnt, 0);
      checkVal("mrst_tready", sReady, 0);
      setPort(0, 1, 64'hF0, 1);
      step;
      checkVal("mrst_next_grant", grant, 4'b0001);
      checkVal("mrst_next_data", mData, 64'hF0);
      step;
      checkVal("mrst_next_pktcnt", pktCnt, 1);
      setPort(0, 0, 0, 0);
      setPort(2, 0, 0, 0);
      step;

      monOn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_fifo_rr_arbiter.md
Name: axis_fifo_rr_arbiter

Overview:
Packet-level round-robin arbiter that shares one 64-bit AXI-Stream FIFO input among NUM_PORT upstream requesters. Grants one requester at a time and holds the grant until that packet's TLAST beat is accepted. Starts a new packet only when the downstream FIFO reports at least MIN_FREE free entries. Sits directly in front of the FIFO's slave port and reads the FIFO's occupancy count.

Parameters:
NUM_PORT, 4, number of requesting AXIS slave ports (2..8)
DATA_W, 64, TDATA width; TKEEP width is DATA_W/8
FIFO_DEPTH, 512, depth of the downstream FIFO in beats
MIN_FREE, 16, minimum free FIFO entries required to start a new packet
ID_W, 2, width of oM_AXIS_TID, equal to clog2(NUM_PORT)

Ports:
iSYS_CLK  in  1  system clock; all logic is on the rising edge
iSYS_RST  in  1  reset, synchronous, active-high
iS_AXIS_TVALID  in  NUM_PORT  per-port valid
oS_AXIS_TREADY  out  NUM_PORT  per-port ready
iS_AXIS_TDATA  in  NUM_PORT*DATA_W  per-port data; port k occupies bits [k*DATA_W +: DATA_W]
iS_AXIS_TKEEP  in  NUM_PORT*DATA_W/8  per-port keep, packed the same way
iS_AXIS_TLAST  in  NUM_PORT  per-port end-of-packet
oM_AXIS_TVALID  out  1  valid to the FIFO
iM_AXIS_TREADY  in  1  ready from the FIFO
oM_AXIS_TDATA  out  DATA_W  data to the FIFO
oM_AXIS_TKEEP  out  DATA_W/8  keep to the FIFO
oM_AXIS_TLAST  out  1  last to the FIFO
oM_AXIS_TID  out  ID_W  index of the granted port
iFIFO_DATA_COUNT  in  32  current FIFO occupancy in beats
oGRANT  out  NUM_PORT  one-hot grant register; all zero when idle
oBUSY  out  1  high while a packet is locked
oPKT_CNT  out  32  number of packets forwarded since reset

Behaviour:
- Free space: free = FIFO_DEPTH - iFIFO_DATA_COUNT, saturating at 0 when the count exceeds FIFO_DEPTH. Start is allowed when free >= MIN_FREE; equality counts as allowed.
- Reset (iSYS_RST=1 at a rising edge):
  - State becomes IDLE.
  - oGRANT, oBUSY, oPKT_CNT and oM_AXIS_TID are cleared to 0.
  - The last-grant pointer is set to NUM_PORT-1, so port 0 has first priority.
  - Reset mid-packet aborts the packet with no flush or completion of the TLAST beat.
- FSM with two states, IDLE and XFER.
  - IDLE:
    - oS_AXIS_TREADY=0 and oM_AXIS_TVALID=0. TDATA, TKEEP and TLAST outputs are driven to 0.
    - If any iS_AXIS_TVALID is high and start is allowed, grant the first valid port scanning upward from (last_grant+1) mod NUM_PORT.
    - On a grant: register it in oGRANT and oM_AXIS_TID, set oBUSY, and move to XFER on the next edge.
    - Otherwise remain in IDLE.
  - XFER with granted port g (combinational datapath, zero-cycle data latency):
    - oM_AXIS_TVALID = TVALID[g], oM_AXIS_TDATA/TKEEP/TLAST = port g's signals.
    - oS_AXIS_TREADY[g] = iM_AXIS_TREADY. All other TREADY bits are 0.
    - A beat transfers when oM_AXIS_TVALID and iM_AXIS_TREADY are both high.
    - On a transfer with TLAST=1: oPKT_CNT increments (wraps at 2^32), last_grant becomes g, oGRANT and oBUSY clear, and the next state is IDLE.
- The grant is locked through bubbles. TVALID[g] low mid-packet or iM_AXIS_TREADY low holds the grant indefinitely.
- The free-space check applies only when a packet starts. It is not rechecked mid-packet, because the FIFO's own TREADY provides backpressure.
- There is a minimum 1-cycle IDLE gap between consecutive packets. A single-beat packet takes exactly 2 cycles: the grant cycle, then the beat.
- Non-granted ports see TREADY=0 and must hold their data (AXIS rule). Their requests stay pending until they are granted.
- Invariants:
  - oGRANT is always zero or one-hot.
  - oM_AXIS_TID equals the index of the set bit in oGRANT.
  - At most one oS_AXIS_TREADY bit is high in any cycle.

Test Plan:
- Single requester: after reset, port 0 sends 2 beats (0xDEADBEEFCAFEBABE, then 0x0123456789ABCDEF with TLAST=1), TREADY=1, count=0 -> grant in cycle 1; beats out on cycles 2-3 with TID=0; oPKT_CNT=1; IDLE on cycle 4.
- Round-robin: all 4 ports continuously valid with 1-beat packets -> grant order 0,1,2,3,0; each packet costs 2 cycles; oPKT_CNT=5 after 10 cycles.
- Packet lock: port 1 sends a 4-beat packet with TVALID low for 3 cycles mid-packet while port 2 is valid -> port 2 TREADY stays 0 and oGRANT stays 0010 until port 1's TLAST is accepted; port 2 is granted next.
- Threshold: FIFO_DEPTH=512, MIN_FREE=16, iFIFO_DATA_COUNT=497 (free 15) with port 0 valid -> no grant; count=496 (free 16) -> grant on the next edge. count=600 -> free saturates to 0, no grant.
- Backpressure: iM_AXIS_TREADY toggles 1,0,0,1 during a 3-beat packet -> oM_AXIS_TDATA holds while ready is low; exactly 3 transfers; oS_AXIS_TREADY[g] mirrors iM_AXIS_TREADY.
- Reset mid-packet: assert iSYS_RST for 1 cycle after beat 2 of 4 -> next cycle oGRANT=0, oBUSY=0, oPKT_CNT=0, all TREADY=0; the next grant goes to port 0 if it is valid.
